// File: rtl/intdiv_iter_if.sv
// Divider request/response bundle between Execute and the iterative divider.
interface intdiv_iter_if #(
  parameter int unsigned XLEN = 64
);
  logic            IntDivE;
  logic            FlushE;
  logic [2:0]      Funct3E;
  logic            W64E;
  logic [XLEN-1:0] ForwardedSrcAE;
  logic [XLEN-1:0] ForwardedSrcBE;
  logic            DivBusyE;
  logic            DivDone;
  logic [XLEN-1:0] DivResult;

  // Execute side: issues operations, watches busy/done.
  modport master (
    output IntDivE, FlushE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE,
    input  DivBusyE, DivDone, DivResult
  );

  // Divider side.
  modport slave (
    input  IntDivE, FlushE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE,
    output DivBusyE, DivDone, DivResult
  );
endinterface

// File: rtl/intdiv_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and the RV64 W forms.
// One quotient bit per cycle, MSB first. Divide-by-zero and signed overflow are
// resolved at start without iterating.
// Optional: define INTDIV_EARLYTERM_EN to skip the leading zeros of |dividend|.
module intdiv_iter #(
  parameter int unsigned XLEN = 64
) (
  input logic           clk,
  input logic           reset,
  intdiv_iter_if.slave  divIf
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} divStateT;

  divStateT        stateQ;
  logic [XLEN:0]   remQ;
  logic [XLEN-1:0] quoQ;
  logic [XLEN-1:0] divisorQ;
  logic [CntW-1:0] cntQ;
  logic            negQuoQ;
  logic            negRemQ;
  logic            isRemQ;
  logic            wModeQ;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] x, input logic sgn);
    logic [XLEN-1:0] r;
    if (sgn) r = XLEN'($signed(x));
    else     r = XLEN'(x);
    return r;
  endfunction

  logic            isSigned, isRem, wMode;
  logic [XLEN-1:0] opA, opB, magA, magB;
  logic            negA, negB;
  logic            divByZero, overflow, zeroDividend, startSpecial;
  logic [XLEN-1:0] rawSpecial, specialRes;
  logic [XLEN-1:0] shA, startQuo;
  logic [CntW-1:0] nMinus1, startCnt;

  // Decode the request and normalise operands to magnitudes.
  always_comb begin
    isSigned  = ~divIf.Funct3E[0];
    isRem     = divIf.Funct3E[1];
    wMode     = divIf.W64E & (XLEN == 64);
    opA       = wMode ? ext32(divIf.ForwardedSrcAE[31:0], isSigned) : divIf.ForwardedSrcAE;
    opB       = wMode ? ext32(divIf.ForwardedSrcBE[31:0], isSigned) : divIf.ForwardedSrcBE;
    negA      = isSigned & opA[XLEN-1];
    negB      = isSigned & opB[XLEN-1];
    magA      = negA ? -opA : opA;
    magB      = negB ? -opB : opB;
    divByZero = (opB == '0);
    // The W operands are sign-extended, so checking the low word suffices there.
    overflow  = isSigned && (opB == '1) &&
                (wMode ? (opA[31:0] == 32'h8000_0000)
                       : (opA == {1'b1, {(XLEN-1){1'b0}}}));
    nMinus1   = wMode ? CntW'(31) : CntW'(XLEN - 1);
    // Left-align the dividend so the iteration always consumes bit XLEN-1.
    shA       = wMode ? (magA << 32) : magA;
  end

`ifdef INTDIV_EARLYTERM_EN
  localparam int unsigned ClzW = $clog2(XLEN + 1);
  logic [ClzW-1:0] lz;
  logic            lzFound;

  // Leading-zero count of the aligned dividend magnitude.
  always_comb begin
    lz      = '0;
    lzFound = 1'b0;
    for (int i = int'(XLEN) - 1; i >= 0; i--) begin
      if (!lzFound) begin
        if (shA[i]) lzFound = 1'b1;
        else        lz = lz + ClzW'(1);
      end
    end
    startQuo     = shA << lz;
    startCnt     = nMinus1 - CntW'(lz);
    zeroDividend = (magA == '0);
  end
`else
  // Fixed-latency start: full N iterations.
  always_comb begin
    startQuo     = shA;
    startCnt     = nMinus1;
    zeroDividend = 1'b0;
  end
`endif

  // Results for the cases that skip iteration.
  always_comb begin
    if (divByZero)     rawSpecial = isRem ? opA : '1;
    else if (overflow) rawSpecial = isRem ? '0 : opA;
    else               rawSpecial = '0;
    specialRes   = wMode ? ext32(rawSpecial[31:0], 1'b1) : rawSpecial;
    startSpecial = divByZero | overflow | zeroDividend;
  end

  logic [XLEN:0]   remShift, remNext;
  logic            geq;
  logic [XLEN-1:0] quoNext, qSgn, rSgn, rawFinal, finalRes;

  // One restoring compare/subtract step plus final sign fix-up.
  always_comb begin
    remShift = {remQ[XLEN-1:0], quoQ[XLEN-1]};
    geq      = (remShift >= {1'b0, divisorQ});
    remNext  = geq ? (remShift - {1'b0, divisorQ}) : remShift;
    quoNext  = {quoQ[XLEN-2:0], geq};
    qSgn     = negQuoQ ? -quoNext : quoNext;
    rSgn     = negRemQ ? -remNext[XLEN-1:0] : remNext[XLEN-1:0];
    rawFinal = isRemQ ? rSgn : qSgn;
    finalRes = wModeQ ? ext32(rawFinal[31:0], 1'b1) : rawFinal;
  end

  // Top remainder bit is always clear after a step; funct3[2] is fixed by decode.
  logic [1:0] unusedBits;
  assign unusedBits = {remQ[XLEN], divIf.Funct3E[2]};

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ          <= StIdle;
      remQ            <= '0;
      quoQ            <= '0;
      divisorQ        <= '0;
      cntQ            <= '0;
      negQuoQ         <= 1'b0;
      negRemQ         <= 1'b0;
      isRemQ          <= 1'b0;
      wModeQ          <= 1'b0;
      divIf.DivBusyE  <= 1'b0;
      divIf.DivDone   <= 1'b0;
      divIf.DivResult <= '0;
    end else begin
      case (stateQ)
        StIdle: begin
          divIf.DivDone <= 1'b0;
          if (divIf.IntDivE && !divIf.FlushE) begin
            isRemQ  <= isRem;
            wModeQ  <= wMode;
            negQuoQ <= negA ^ negB;
            negRemQ <= negA;
            if (startSpecial) begin
              stateQ          <= StDone;
              divIf.DivDone   <= 1'b1;
              divIf.DivResult <= specialRes;
            end else begin
              stateQ         <= StBusy;
              divIf.DivBusyE <= 1'b1;
              remQ           <= '0;
              quoQ           <= startQuo;
              divisorQ       <= magB;
              cntQ           <= startCnt;
            end
          end
        end
        StBusy: begin
          if (divIf.FlushE) begin
            stateQ         <= StIdle;
            divIf.DivBusyE <= 1'b0;
          end else begin
            remQ <= remNext;
            quoQ <= quoNext;
            cntQ <= cntQ - CntW'(1);
            if (cntQ == '0) begin
              stateQ          <= StDone;
              divIf.DivBusyE  <= 1'b0;
              divIf.DivDone   <= 1'b1;
              divIf.DivResult <= finalRes;
            end
          end
        end
        StDone: begin
          stateQ         <= StIdle;
          divIf.DivDone  <= 1'b0;
          divIf.DivBusyE <= 1'b0;
        end
        default: begin
          stateQ         <= StIdle;
          divIf.DivDone  <= 1'b0;
          divIf.DivBusyE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_iter.sv
// Scoreboard bench for intdiv_iter (XLEN=64). Expected results and latencies
// come from a plain-arithmetic reference model; a monitor compares on DivDone.
module tb_intdiv_iter;
  localparam int unsigned XLEN = 64;
  localparam logic [2:0] FDiv = 3'b100, FDivu = 3'b101, FRem = 3'b110, FRemu = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  intdiv_iter_if #(.XLEN(XLEN)) divIf ();
  intdiv_iter #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .divIf(divIf));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          start;
    int          tag;
  } expT;
  expT expQ[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference result straight from the arithmetic rules.
  function automatic logic [63:0] refResult(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic        sgn;
    logic        rem;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    sgn = ~f3[0];
    rem = f3[1];
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'h0 : a32;
      else if (sgn) r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else r32 = rem ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 0) r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r64 = rem ? 64'h0 : a;
    else if (sgn) r64 = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else r64 = rem ? a % b : a / b;
    return r64;
  endfunction

  // Reference latency: cycles from the start edge to the DivDone cycle, inclusive.
  function automatic int refLat(input logic [2:0] f3, input logic w,
                                input logic [63:0] a, input logic [63:0] b);
    logic        sgn;
    logic [63:0] ea, eb, mag;
    int          n, bits;
    sgn  = ~f3[0];
    n    = w ? 32 : 64;
    ea   = w ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'h0, a[31:0]}) : a;
    eb   = w ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'h0, b[31:0]}) : b;
    if (eb == 0) return 1;
    if (sgn && eb == 64'hFFFF_FFFF_FFFF_FFFF &&
        (w ? ea[31:0] == 32'h8000_0000 : ea == 64'h8000_0000_0000_0000)) return 1;
`ifdef INTDIV_EARLYTERM_EN
    mag  = (sgn && ea[63]) ? -ea : ea;
    if (mag == 0) return 1;
    bits = 0;
    while (mag != 0) begin
      bits++;
      mag = mag >> 1;
    end
    return bits + 1;
`else
    mag  = ea;
    bits = n;
    return bits + 1 + 0 * int'(mag[0]);
`endif
  endfunction

  // Issue one op from a negedge; returns at the negedge after the start edge.
  task automatic startOp(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int tag, input int hold);
    expT e;
    divIf.Funct3E        = f3;
    divIf.W64E           = w;
    divIf.ForwardedSrcAE = a;
    divIf.ForwardedSrcBE = b;
    divIf.IntDivE        = 1'b1;
    @(posedge clk);
    #1;
    e.res   = refResult(f3, w, a, b);
    e.lat   = refLat(f3, w, a, b);
    e.start = cyc;
    e.tag   = tag;
    expQ.push_back(e);
    @(negedge clk);
    repeat (hold) @(negedge clk);
    divIf.IntDivE = 1'b0;
  endtask

  // Wait for the scoreboard to drain, then one more cycle so the DUT is idle.
  task automatic waitDone();
    int i;
    i = 0;
    while (expQ.size() != 0 && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL doneTimeout actual=pending%0d required=none", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic runOp(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input int tag);
    startOp(f3, w, a, b, tag, 0);
    waitDone();
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra, rb;
    logic [2:0]  rf;
    logic        rw;
    int          kind;

    divIf.IntDivE        = 1'b0;
    divIf.FlushE         = 1'b0;
    divIf.Funct3E        = FDivu;
    divIf.W64E           = 1'b0;
    divIf.ForwardedSrcAE = '0;
    divIf.ForwardedSrcBE = '0;

    fork
      begin : monitor
        expT e;
        forever begin
          @(negedge clk);
          if (reset && divIf.DivDone) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpectedDone actual=DivDone required=idle result=%h",
                       divIf.DivResult);
            end else begin
              e = expQ.pop_front();
              chk($sformatf("result%0d", e.tag), divIf.DivResult, e.res);
              chk($sformatf("latency%0d", e.tag), 64'(cyc - e.start + 1), 64'(e.lat));
              chk($sformatf("busyAtDone%0d", e.tag), 64'(divIf.DivBusyE), 64'(0));
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("resetBusy", 64'(divIf.DivBusyE), 64'(0));
    chk("resetDone", 64'(divIf.DivDone), 64'(0));
    chk("resetResult", divIf.DivResult, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    runOp(FDivu, 1'b0, 64'd100, 64'd7, 1);
    runOp(FRemu, 1'b0, 64'd100, 64'd7, 2);
    runOp(FDiv, 1'b0, -64'sd7, 64'd2, 3);
    runOp(FRem, 1'b0, -64'sd7, 64'd2, 4);
    runOp(FDivu, 1'b0, 64'd5, 64'd0, 5);
    runOp(FRemu, 1'b0, 64'd5, 64'd0, 6);
    runOp(FDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 7);
    runOp(FRem, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8);
    runOp(FDiv, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 9);
    runOp(FDivu, 1'b0, 64'd3, 64'd1, 10);
    runOp(FRemuW(), 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd10, 11);
    runOp(FDivu, 1'b0, 64'd0, 64'd9, 12);

    // IntDivE held through most of BUSY must not restart the op.
    startOp(FDivu, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 13, 20);
    waitDone();

    // Flush mid-operation: busy drops next cycle and no DivDone follows.
    startOp(FDivu, 1'b0, 64'd100, 64'd7, 14, 0);
    repeat (9) @(negedge clk);
    chk("busyBeforeFlush", 64'(divIf.DivBusyE), 64'(1));
    divIf.FlushE = 1'b1;
    @(posedge clk);
    #1;
    chk("busyAfterFlush", 64'(divIf.DivBusyE), 64'(0));
    divIf.FlushE = 1'b0;
    void'(expQ.pop_back());
    repeat (80) @(negedge clk);
    runOp(FDivu, 1'b0, 64'd9, 64'd3, 15);

    // Flush and start together in IDLE: no start.
    divIf.Funct3E        = FDivu;
    divIf.W64E           = 1'b0;
    divIf.ForwardedSrcAE = 64'd5;
    divIf.ForwardedSrcBE = 64'd0;
    divIf.IntDivE        = 1'b1;
    divIf.FlushE         = 1'b1;
    @(posedge clk);
    #1;
    chk("flushStartBusy", 64'(divIf.DivBusyE), 64'(0));
    chk("flushStartDone", 64'(divIf.DivDone), 64'(0));
    divIf.IntDivE = 1'b0;
    divIf.FlushE  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-operation clears everything at once.
    startOp(FDivu, 1'b0, 64'd100, 64'd7, 16, 0);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midResetBusy", 64'(divIf.DivBusyE), 64'(0));
    chk("midResetDone", 64'(divIf.DivDone), 64'(0));
    chk("midResetResult", divIf.DivResult, 64'h0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    runOp(FRem, 1'b0, 64'd17, -64'sd5, 17);

    for (int i = 0; i < 800; i++) begin
      kind = int'($urandom_range(0, 9));
      rf   = {1'b1, 2'($urandom_range(0, 3))};
      rw   = 1'($urandom_range(0, 1));
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      case (kind)
        0: rb = 64'h0;
        1: begin
          ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          rb = '1;
          rf = {2'b10, 1'($urandom_range(0, 1))};
        end
        2: ra = 64'($urandom_range(0, 300));
        3: rb = 64'($urandom_range(1, 20));
        4: begin
          ra = -64'($urandom_range(0, 1000));
          rb = -64'($urandom_range(1, 30));
        end
        5: rb = {32'h0, $urandom};
        default: ;
      endcase
      runOp(rf, rw, ra, rb, 100 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [2:0] FRemuW();
    return FRemu;
  endfunction

endmodule
